mem_write_scheduler: RTL and testbench
======================================

Name: mem_write_scheduler

Overview:
Sequences a transfer job that lands two decompressor output streams in one single-port memory. Each stream gets a small input FIFO, a base address and a word count. The block arbitrates the shared write port round-robin, generates incrementing addresses per stream, and signals job completion to the system. It sits between the decompressors and the memory write port.

Parameters:
N, 32, data word width
AW, 16, memory address width
DEPTH, 4, per-stream FIFO depth in words (power of 2, >=2)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; latches job config, starts job (accepted in IDLE or DONE)
base1  in  AW  stream 1 start address, sampled on start
base2  in  AW  stream 2 start address, sampled on start
count1  in  AW  words stream 1 will deliver, sampled on start
count2  in  AW  words stream 2 will deliver, sampled on start
store1  in  1  stream 1 data valid
data1  in  N  stream 1 data
ready1  out  1  stream 1 FIFO can accept
store2  in  1  stream 2 data valid
data2  in  N  stream 2 data
ready2  out  1  stream 2 FIFO can accept
mem_stall  in  1  memory cannot accept a write this cycle
mem_we  out  1  write enable (registered)
mem_addr  out  AW  write address (registered)
mem_data  out  N  write data (registered)
done  out  1  job complete
err  out  1  sticky: a stream pushed more words than its count

Behaviour:
- Reset (reset=0, async): state IDLE, both FIFOs empty, ready1/2=0, mem_we=0, mem_addr=0, mem_data=0, done=0, err=0, last-grant=stream 2. Reset mid-job aborts it; in-flight data is discarded.
- States: IDLE -> RUN on start. RUN -> DONE when both remaining-push counters are 0, both FIFOs are empty and no write is pending. DONE -> RUN on start. done=1 only in DONE.
- On start: addr_k<=base_k, rem_k<=count_k, err<=0. If count1=count2=0, RUN lasts exactly one cycle, then DONE.
- Push: in RUN, store_k & ready_k writes data_k into FIFO k and decrements rem_k. ready_k = (state==RUN) & FIFO k not full. A push into a full FIFO is not allowed, even with a same-cycle pop. store_k outside RUN is ignored.
- Overrun: store_k with ready_k=1 and rem_k=0 drops the word and sets err=1. err stays set until the next start or reset.
- Write acceptance: a write completes on an edge where mem_we=1 and mem_stall=0. While mem_stall=1 and mem_we=1, mem_we, mem_addr and mem_data hold and nothing is popped.
- Grant: on an edge where the output register is free (mem_we=0, or write completing), pick a non-empty FIFO. If both are non-empty, grant the stream not granted last. If only one is non-empty, grant it. On grant: pop the head into mem_data, mem_addr<=addr_k, mem_we<=1, addr_k<=addr_k+1 (mod 2^AW), last-grant<=k. If nothing is eligible: mem_we<=0.
- Throughput: one write per cycle when unstalled.
- Latency: a word pushed at edge E appears on mem_we/mem_data after edge E+1 at the earliest.
- Simultaneous push and pop on a non-full FIFO are both performed.
- Stream order is preserved within each stream.

Optional Feature:
STREAM1_PRIORITY_EN: when defined, stream 1 wins every tie (fixed priority) and last-grant is unused. When undefined, round-robin as above.

Test Plan:
- Single stream: start base1=0x0100, count1=3, count2=0; push A,B,C back-to-back -> writes (0x0100,A), (0x0101,B), (0x0102,C) on consecutive cycles; first write 2 edges after first push; done=1 the cycle after the last write; err=0.
- Contention: base1=0x0000, base2=0x8000, count=2 each; both push every cycle -> writes alternate 0x0000, 0x8000, 0x0001, 0x8001 (stream 1 first after reset); with STREAM1_PRIORITY_EN, both stream 1 writes go first.
- Stall/backpressure: mem_stall=1 for 6 cycles with stream 1 pushing -> mem_we/addr/data held; ready1=0 once DEPTH words plus 1 pending are buffered; after release, no word is lost or duplicated.
- Overrun: count1=1, push 2 words -> one write only; err=1 until the next start.
- Address wrap: base1=0xFFFF, count1=2 -> writes to 0xFFFF then 0x0000.
- Reset mid-job: reset low during RUN with FIFOs non-empty -> all outputs 0 immediately, state IDLE, no further writes after reset is released.

Source files
------------

// File: rtl/mem_write_scheduler.sv
// Round-robin write scheduler: two stream FIFOs share one memory write port.
// Optional macro STREAM1_PRIORITY_EN gives stream 1 fixed priority on ties.

module mws_fifo #(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PONE = 1;

    logic [N-1:0] buf_q [DEPTH];
    logic [PW:0]  wptr_q, wptr_d, rptr_q, rptr_d;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) wptr_d = wptr_q + PONE;
        if (pop)  rptr_d = rptr_q + PONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) buf_q[wptr_q[PW-1:0]] <= din;
    end

    assign dout  = buf_q[rptr_q[PW-1:0]];
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
endmodule

module mem_write_scheduler #(
    parameter int N     = 32,
    parameter int AW    = 16,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base1,
    input  logic [AW-1:0] base2,
    input  logic [AW-1:0] count1,
    input  logic [AW-1:0] count2,
    input  logic          store1,
    input  logic [N-1:0]  data1,
    output logic          ready1,
    input  logic          store2,
    input  logic [N-1:0]  data2,
    output logic          ready2,
    input  logic          mem_stall,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [N-1:0]  mem_data,
    output logic          done,
    output logic          err
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [AW-1:0] ONE = 1;

    state_t        state_q, state_d;
    logic [AW-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
    logic [AW-1:0] rem1_q, rem1_d, rem2_q, rem2_d;
    logic          last_q, last_d;   // 1: stream 2 was granted last
    logic          err_q, err_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [N-1:0]  mem_data_q, mem_data_d;

    logic          run, out_free, push1, push2, pick1, pick2;
    logic          full1, full2, empty1, empty2;
    logic [N-1:0]  head1, head2;

    assign run      = (state_q == RUN);
    assign ready1   = run & ~full1;
    assign ready2   = run & ~full2;
    assign push1    = store1 & ready1 & (rem1_q != '0);
    assign push2    = store2 & ready2 & (rem2_q != '0);
    assign out_free = ~mem_we_q | ~mem_stall;

    mws_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo1 (
        .clk(clk), .rst_n(reset), .push(push1), .pop(pick1), .din(data1),
        .dout(head1), .empty(empty1), .full(full1)
    );

    mws_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo2 (
        .clk(clk), .rst_n(reset), .push(push2), .pop(pick2), .din(data2),
        .dout(head2), .empty(empty2), .full(full2)
    );

    always_comb begin
        pick1 = 1'b0;
        pick2 = 1'b0;
        if (out_free) begin
            if (!empty1 && !empty2) begin
`ifdef STREAM1_PRIORITY_EN
                pick1 = 1'b1;
`else
                pick1 = last_q;
                pick2 = ~last_q;
`endif
            end else if (!empty1) begin
                pick1 = 1'b1;
            end else if (!empty2) begin
                pick2 = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        addr1_d    = addr1_q;
        addr2_d    = addr2_q;
        rem1_d     = rem1_q;
        rem2_d     = rem2_q;
        last_d     = last_q;
        err_d      = err_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;

        if (push1) rem1_d = rem1_q - ONE;
        if (push2) rem2_d = rem2_q - ONE;
        // A word offered beyond the announced count is dropped and flagged.
        if ((store1 && ready1 && rem1_q == '0) || (store2 && ready2 && rem2_q == '0))
            err_d = 1'b1;

        if (out_free) begin
            mem_we_d = pick1 | pick2;
            if (pick1) begin
                mem_addr_d = addr1_q;
                mem_data_d = head1;
                addr1_d    = addr1_q + ONE;
                last_d     = 1'b0;
            end else if (pick2) begin
                mem_addr_d = addr2_q;
                mem_data_d = head2;
                addr2_d    = addr2_q + ONE;
                last_d     = 1'b1;
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    addr1_d = base1;
                    addr2_d = base2;
                    rem1_d  = count1;
                    rem2_d  = count2;
                    err_d   = 1'b0;
                end
            end
            RUN: begin
                // A write completing on this edge no longer counts as pending.
                if (rem1_q == '0 && rem2_q == '0 && empty1 && empty2 &&
                    !(mem_we_q && mem_stall))
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            addr1_q    <= '0;
            addr2_q    <= '0;
            rem1_q     <= '0;
            rem2_q     <= '0;
            last_q     <= 1'b1;
            err_q      <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            addr1_q    <= addr1_d;
            addr2_q    <= addr2_d;
            rem1_q     <= rem1_d;
            rem2_q     <= rem2_d;
            last_q     <= last_d;
            err_q      <= err_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign done     = (state_q == DONE);
    assign err      = err_q;
endmodule

// File: tb/tb_mem_write_scheduler.sv
// Directed bench for mem_write_scheduler; inputs driven on negedge, outputs sampled there too.
module tb_mem_write_scheduler;
    localparam int N = 32, AW = 16, DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n, start, store1, store2, mem_stall;
    logic [AW-1:0] base1, base2, count1, count2;
    logic [N-1:0] data1, data2;
    logic ready1, ready2, mem_we, done, err;
    logic [AW-1:0] mem_addr;
    logic [N-1:0] mem_data;

    int n_assert = 0;
    int n_fail = 0;
    int wr_n = 0;
    int wr_base;
    logic [AW-1:0] wr_addr [64];
    logic [N-1:0]  wr_data [64];
    logic [AW-1:0] exp_a [4];
    logic [N-1:0]  exp_d [4];

    mem_write_scheduler #(.N(N), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(rst_n), .start(start),
        .base1(base1), .base2(base2), .count1(count1), .count2(count2),
        .store1(store1), .data1(data1), .ready1(ready1),
        .store2(store2), .data2(data2), .ready2(ready2),
        .mem_stall(mem_stall), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_data(mem_data), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Log every completed write (values seen just before the edge).
    always @(posedge clk) begin
        if (rst_n === 1'b1 && mem_we === 1'b1 && mem_stall === 1'b0) begin
            if (wr_n < 64) begin
                wr_addr[wr_n] <= mem_addr;
                wr_data[wr_n] <= mem_data;
            end
            wr_n <= wr_n + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [AW-1:0] b1, input logic [AW-1:0] c1,
                             input logic [AW-1:0] b2, input logic [AW-1:0] c2);
        @(negedge clk);
        base1 = b1; count1 = c1; base2 = b2; count2 = c2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 0; store1 = 0; store2 = 0; mem_stall = 0;
        base1 = '0; base2 = '0; count1 = '0; count2 = '0; data1 = '0; data2 = '0;
        #12;
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_data", mem_data, 0);
        chk("rst_ready1", ready1, 0);
        chk("rst_ready2", ready2, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Contention: both streams push two words each.
`ifdef STREAM1_PRIORITY_EN
        exp_a = '{16'h0000, 16'h0001, 16'h8000, 16'h8001};
        exp_d = '{32'h1111_0001, 32'h1111_0002, 32'h2222_0001, 32'h2222_0002};
`else
        exp_a = '{16'h0000, 16'h8000, 16'h0001, 16'h8001};
        exp_d = '{32'h1111_0001, 32'h2222_0001, 32'h1111_0002, 32'h2222_0002};
`endif
        start_job(16'h0000, 16'd2, 16'h8000, 16'd2);
        chk("cont_ready1", ready1, 1);
        chk("cont_ready2", ready2, 1);
        store1 = 1; store2 = 1; data1 = 32'h1111_0001; data2 = 32'h2222_0001;
        @(negedge clk);
        data1 = 32'h1111_0002; data2 = 32'h2222_0002;
        @(negedge clk);
        store1 = 0; store2 = 0;
        for (int i = 0; i < 4; i++) begin
            chk("cont_we", mem_we, 1);
            chk($sformatf("cont_addr%0d", i), mem_addr, exp_a[i]);
            chk($sformatf("cont_data%0d", i), mem_data, exp_d[i]);
            @(negedge clk);
        end
        chk("cont_done", done, 1);
        chk("cont_nwr", wr_n, 4);

        // Single stream, back-to-back pushes.
        wr_base = wr_n;
        start_job(16'h0100, 16'd3, 16'h0000, 16'd0);
        chk("ss_run_done", done, 0);
        store1 = 1; data1 = 32'hAAAA_0001;
        @(negedge clk);
        chk("ss_lat_we", mem_we, 0);
        data1 = 32'hAAAA_0002;
        @(negedge clk);
        data1 = 32'hAAAA_0003;
        chk("ss_we0", mem_we, 1);
        chk("ss_addr0", mem_addr, 16'h0100);
        chk("ss_data0", mem_data, 32'hAAAA_0001);
        @(negedge clk);
        store1 = 0;
        chk("ss_addr1", mem_addr, 16'h0101);
        chk("ss_data1", mem_data, 32'hAAAA_0002);
        @(negedge clk);
        chk("ss_addr2", mem_addr, 16'h0102);
        chk("ss_data2", mem_data, 32'hAAAA_0003);
        chk("ss_notdone", done, 0);
        @(negedge clk);
        chk("ss_we_off", mem_we, 0);
        chk("ss_done", done, 1);
        chk("ss_err", err, 0);
        chk("ss_nwr", wr_n - wr_base, 3);

        // Stall and backpressure.
        wr_base = wr_n;
        mem_stall = 1;
        start_job(16'h0200, 16'd6, 16'h0000, 16'd0);
        store1 = 1; data1 = 32'hC000_0000;
        @(negedge clk); data1 = 32'hC000_0001;
        @(negedge clk); data1 = 32'hC000_0002;
        chk("st_we", mem_we, 1);
        chk("st_addr", mem_addr, 16'h0200);
        @(negedge clk); data1 = 32'hC000_0003;
        @(negedge clk); data1 = 32'hC000_0004;
        chk("st_ready_room", ready1, 1);
        @(negedge clk); store1 = 0;
        chk("st_ready_full", ready1, 0);
        repeat (3) @(negedge clk);
        chk("st_hold_we", mem_we, 1);
        chk("st_hold_addr", mem_addr, 16'h0200);
        chk("st_hold_data", mem_data, 32'hC000_0000);
        chk("st_hold_ready", ready1, 0);
        chk("st_no_wr", wr_n - wr_base, 0);
        mem_stall = 0;
        @(negedge clk);
        chk("st_ready_again", ready1, 1);
        chk("st_addr_rel", mem_addr, 16'h0201);
        store1 = 1; data1 = 32'hC000_0005;
        @(negedge clk); store1 = 0;
        repeat (5) @(negedge clk);
        chk("st_done", done, 1);
        chk("st_nwr", wr_n - wr_base, 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("st_log_addr%0d", i), wr_addr[wr_base + i], 16'h0200 + 16'(i));
            chk($sformatf("st_log_data%0d", i), wr_data[wr_base + i], 32'hC000_0000 + 32'(i));
        end

        // Overrun: two pushes against a count of one.
        wr_base = wr_n;
        start_job(16'h0300, 16'd1, 16'h0000, 16'd0);
        store1 = 1; data1 = 32'hD000_0000;
        @(negedge clk); data1 = 32'hD000_0001;
        @(negedge clk); store1 = 0;
        chk("ov_err", err, 1);
        chk("ov_addr", mem_addr, 16'h0300);
        chk("ov_data", mem_data, 32'hD000_0000);
        @(negedge clk);
        chk("ov_done", done, 1);
        chk("ov_err_sticky", err, 1);
        @(negedge clk);
        chk("ov_nwr", wr_n - wr_base, 1);

        // Address wrap; start also clears err.
        start_job(16'hFFFF, 16'd2, 16'h0000, 16'd0);
        chk("wr_err_clr", err, 0);
        store1 = 1; data1 = 32'hE000_0000;
        @(negedge clk); data1 = 32'hE000_0001;
        @(negedge clk); store1 = 0;
        chk("wrap_addr0", mem_addr, 16'hFFFF);
        @(negedge clk);
        chk("wrap_addr1", mem_addr, 16'h0000);
        chk("wrap_data1", mem_data, 32'hE000_0001);
        @(negedge clk);
        chk("wrap_done", done, 1);

        // Zero-length job: one RUN cycle then DONE.
        start_job(16'h0000, 16'd0, 16'h0000, 16'd0);
        chk("zero_run", done, 0);
        @(negedge clk);
        chk("zero_done", done, 1);

        // Reset mid-job with data buffered.
        mem_stall = 1;
        start_job(16'h0400, 16'd4, 16'h0500, 16'd4);
        store1 = 1; store2 = 1; data1 = 32'hF100_0000; data2 = 32'hF200_0000;
        @(negedge clk);
        @(negedge clk); store1 = 0; store2 = 0;
        chk("mid_pre_we", mem_we, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_we", mem_we, 0);
        chk("mid_addr", mem_addr, 0);
        chk("mid_data", mem_data, 0);
        chk("mid_ready1", ready1, 0);
        chk("mid_ready2", ready2, 0);
        chk("mid_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1; mem_stall = 0;
        wr_base = wr_n;
        store1 = 1; data1 = 32'hBAD0_0000;
        repeat (4) @(negedge clk);
        store1 = 0;
        chk("post_nwr", wr_n - wr_base, 0);
        chk("post_we", mem_we, 0);
        chk("post_done", done, 0);
        chk("post_ready1", ready1, 0);
        start_job(16'h0600, 16'd1, 16'h0000, 16'd0);
        store1 = 1; data1 = 32'h5A5A_0001;
        @(negedge clk); store1 = 0;
        @(negedge clk);
        chk("post_addr", mem_addr, 16'h0600);
        chk("post_data", mem_data, 32'h5A5A_0001);
        @(negedge clk);
        chk("post_job_done", done, 1);
        chk("post_job_nwr", wr_n - wr_base, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
